audio_gain_stage: RTL and testbench
===================================

AUDIO_GAIN_STAGE -- requirements
Module: audio_gain_stage

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset, ports named as in the codec path.
REQ-002 SHALL have port audio_clk, input, 1 bit: codec-domain clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port NewFrame, input, 1 bit: one-cycle pulse from the codec interface marking valid Rec data.
REQ-005 SHALL have ports LeftRecData and RightRecData, input, 24 bits each: signed two's-complement captured samples.
REQ-006 SHALL have port gain, input, 8 bits: unsigned Q1.7 target gain, where 0x80 is unity.
REQ-007 SHALL have port mute, input, 1 bit: high ramps the gain to 0.
REQ-008 SHALL have ports LeftPlayData and RightPlayData, output, 24 bits each: registered processed samples feeding the codec Play inputs.
REQ-009 SHALL have port clip, output, 1 bit: one-cycle pulse when either channel saturated this frame.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is being processed.
REQ-011 SHALL have port PeakLevel, output, 8 bits: peak-hold meter, present only with the macro in REQ-030.

Function
REQ-012 SHALL implement the states IDLE -> MUL_L -> MUL_R -> UPDATE -> IDLE, advancing unconditionally one state per cycle outside IDLE.
REQ-013 SHALL, in IDLE with NewFrame=1, latch both Rec samples and g_eff and enter MUL_L.
REQ-014 SHALL drive busy=1 in MUL_L, MUL_R and UPDATE, and 0 in IDLE.
REQ-015 SHALL ignore a NewFrame pulse that arrives while busy=1, dropping it without queuing.
REQ-016 SHALL use one shared multiplier: MUL_L computes left, MUL_R computes right.
REQ-017 SHALL compute the product as the signed 24-bit sample times the zero-extended 9-bit g_eff, giving a 33-bit result, then shift arithmetically right by 7 (truncation toward negative infinity).
REQ-018 SHALL saturate the shifted result to [-8388608, 8388607] and mark that channel clipped when saturation occurs.
REQ-019 SHALL update LeftPlayData and RightPlayData together in UPDATE, so outputs change exactly 4 cycles after the NewFrame cycle.
REQ-020 SHALL hold the outputs between updates.
REQ-021 SHALL pulse clip high for exactly the UPDATE cycle when either channel clipped.
REQ-022 SHALL update g_eff (8 bits) once per processed frame in UPDATE: mute=1 decrements toward 0; mute=0 steps by ±1 toward gain; g_eff is unchanged when it equals the target.
REQ-023 SHALL use g_eff latched at MUL_L for the current frame, so a new g_eff takes effect on the next frame.
REQ-024 SHALL sample gain and mute in UPDATE only, so changes mid-frame do not affect the frame in flight.

Reset
REQ-025 SHALL, with reset=0, asynchronously force state=IDLE, LeftPlayData=0, RightPlayData=0, clip=0, busy=0 and g_eff=0.
REQ-026 SHALL, with reset=0, also clear PeakLevel=0 and the decay counter=0 when the macro is defined.
REQ-027 SHALL, on a reset mid-frame, abort the frame with no output update, and the first NewFrame after release starts a fresh frame.
REQ-028 SHALL, after reset, ramp from g_eff=0 up to gain at one step per frame (soft start).
REQ-029 SHALL release reset asynchronously and act on the first rising audio_clk edge after release.

Configuration
REQ-030 SHALL, with macro AUDIO_GAIN_STAGE_PEAK_METER_EN defined, compute in UPDATE m = max(|L|, |R|) from the new outputs, clamping |-8388608| to 8388607.
REQ-031 SHALL, with the macro defined, set PeakLevel to m[22:15] if that value is larger than PeakLevel, else decrement PeakLevel by 1 (floor 0) once every 256 processed frames via an 8-bit frame counter.
REQ-032 SHALL, without the macro, tie PeakLevel to constant 0 and synthesize no meter or counter logic, leaving all other behaviour identical.

Verification
REQ-033 SHALL verify reset, gain=0x80, mute=0, and 200 frames of L=0x100000: g_eff reaches 0x80 at frame 128, after which LeftPlayData=0x100000 with clip=0.
REQ-034 SHALL verify g_eff=0xFF, L=0x7FFFFF, R=0x800000: LeftPlayData=0x7FFFFF, RightPlayData=0x800000, clip pulses one cycle 4 cycles after NewFrame.
REQ-035 SHALL verify g_eff=0x40, L=-3 (0xFFFFFD): LeftPlayData=0xFFFFFE (-2, floor of -1.5).
REQ-036 SHALL verify a second NewFrame 2 cycles after the first: only one UPDATE occurs, outputs reflect the first samples, and busy stays high for 3 cycles.
REQ-037 SHALL verify g_eff=0x80, mute raised: g_eff falls 1 per frame and reaches 0 after 128 frames, then outputs=0; with the macro, PeakLevel holds and then decrements every 256 frames.
REQ-038 SHALL verify reset asserted in MUL_R: outputs=0, busy=0 immediately, and no UPDATE occurs for the aborted frame.

Source files
------------

// File: rtl/audio_gain_stage.sv
// Stereo Q1.7 gain stage with soft-ramped gain, saturation and an optional peak meter (AUDIO_GAIN_STAGE_PEAK_METER_EN).
// Latency: outputs update 4 cycles after NewFrame; NewFrame pulses arriving while busy are dropped.
module audio_gain_stage (
    input  logic        audio_clk,
    input  logic        reset,
    input  logic        NewFrame,
    input  logic [23:0] LeftRecData,
    input  logic [23:0] RightRecData,
    input  logic [7:0]  gain,
    input  logic        mute,
    output logic [23:0] LeftPlayData,
    output logic [23:0] RightPlayData,
    output logic        clip,
    output logic        busy,
    output logic [7:0]  PeakLevel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_L  = 2'd1,
        MUL_R  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam logic signed [32:0] SAT_MAX = 33'sd8388607;
    localparam logic signed [32:0] SAT_MIN = -33'sd8388608;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_busy;
    logic   w_start;

    logic [23:0] r_rec_l;
    logic [23:0] r_rec_r;
    logic [7:0]  r_g_cur;
    logic [7:0]  r_g_eff;
    logic [7:0]  w_g_nxt;
    logic [23:0] r_res_l;
    logic [23:0] r_res_r;
    logic        r_clip_l;
    logic        r_clip_r;
    logic [23:0] r_left_play;
    logic [23:0] r_right_play;
    logic        r_clip;

    logic [23:0]        w_mul_a;
    logic signed [32:0] w_prod;
    logic signed [32:0] w_shift;
    logic [23:0]        w_sat;
    logic               w_sat_hit;

    always_ff @(posedge audio_clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (NewFrame) begin
                    w_start     = 1'b1;
                    w_state_nxt = MUL_L;
                end
            end
            MUL_L:   w_state_nxt = MUL_R;
            MUL_R:   w_state_nxt = UPDATE;
            UPDATE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // One multiplier shared across the two channel cycles.
    assign w_mul_a = (r_state == MUL_R) ? r_rec_r : r_rec_l;
    assign w_prod  = $signed({{9{w_mul_a[23]}}, w_mul_a}) * $signed({25'd0, r_g_cur});
    assign w_shift = w_prod >>> 7;

    always_comb begin
        w_sat     = w_shift[23:0];
        w_sat_hit = 1'b0;
        if (w_shift > SAT_MAX) begin
            w_sat     = 24'h7F_FFFF;
            w_sat_hit = 1'b1;
        end else if (w_shift < SAT_MIN) begin
            w_sat     = 24'h80_0000;
            w_sat_hit = 1'b1;
        end
    end

    // Gain ramps one LSB per processed frame so steps are never audible.
    always_comb begin
        w_g_nxt = r_g_eff;
        if (mute) begin
            if (r_g_eff != 8'd0) begin
                w_g_nxt = r_g_eff - 8'd1;
            end
        end else if (r_g_eff < gain) begin
            w_g_nxt = r_g_eff + 8'd1;
        end else if (r_g_eff > gain) begin
            w_g_nxt = r_g_eff - 8'd1;
        end
    end

    always_ff @(posedge audio_clk or negedge reset) begin
        if (!reset) begin
            r_rec_l      <= 24'd0;
            r_rec_r      <= 24'd0;
            r_g_cur      <= 8'd0;
            r_g_eff      <= 8'd0;
            r_res_l      <= 24'd0;
            r_res_r      <= 24'd0;
            r_clip_l     <= 1'b0;
            r_clip_r     <= 1'b0;
            r_left_play  <= 24'd0;
            r_right_play <= 24'd0;
            r_clip       <= 1'b0;
        end else begin
            r_clip <= 1'b0;
            if (w_start) begin
                r_rec_l <= LeftRecData;
                r_rec_r <= RightRecData;
                r_g_cur <= r_g_eff;
            end
            if (r_state == MUL_L) begin
                r_res_l  <= w_sat;
                r_clip_l <= w_sat_hit;
            end
            if (r_state == MUL_R) begin
                r_res_r  <= w_sat;
                r_clip_r <= w_sat_hit;
            end
            if (r_state == UPDATE) begin
                r_left_play  <= r_res_l;
                r_right_play <= r_res_r;
                r_clip       <= r_clip_l | r_clip_r;
                r_g_eff      <= w_g_nxt;
            end
        end
    end

    assign LeftPlayData  = r_left_play;
    assign RightPlayData = r_right_play;
    assign clip          = r_clip;
    assign busy          = w_busy;

`ifdef AUDIO_GAIN_STAGE_PEAK_METER_EN
    logic [7:0]  r_peak;
    logic [7:0]  r_decay_cnt;
    logic [22:0] w_abs_l;
    logic [22:0] w_abs_r;
    logic [22:0] w_mag;

    // Magnitude with the most negative code clamped to full scale.
    function automatic logic [22:0] abs_clamp(input logic [23:0] x);
        if (!x[23]) begin
            return x[22:0];
        end else if (x[22:0] == 23'd0) begin
            return 23'h7F_FFFF;
        end else begin
            return ~x[22:0] + 23'd1;
        end
    endfunction

    assign w_abs_l = abs_clamp(r_res_l);
    assign w_abs_r = abs_clamp(r_res_r);
    assign w_mag   = (w_abs_l > w_abs_r) ? w_abs_l : w_abs_r;

    always_ff @(posedge audio_clk or negedge reset) begin
        if (!reset) begin
            r_peak      <= 8'd0;
            r_decay_cnt <= 8'd0;
        end else if (r_state == UPDATE) begin
            r_decay_cnt <= r_decay_cnt + 8'd1;
            if (w_mag[22:15] > r_peak) begin
                r_peak <= w_mag[22:15];
            end else if ((r_decay_cnt == 8'hFF) && (r_peak != 8'd0)) begin
                r_peak <= r_peak - 8'd1;
            end
        end
    end

    assign PeakLevel = r_peak;
`else
    assign PeakLevel = 8'd0;
`endif

endmodule

// File: tb/tb_audio_gain_stage.sv
// Randomized bench for audio_gain_stage against a frame-level arithmetic model.
module tb_audio_gain_stage;

    logic        audio_clk = 1'b0;
    logic        reset;
    logic        NewFrame;
    logic [23:0] LeftRecData;
    logic [23:0] RightRecData;
    logic [7:0]  gain;
    logic        mute;
    logic [23:0] LeftPlayData;
    logic [23:0] RightPlayData;
    logic        clip;
    logic        busy;
    logic [7:0]  PeakLevel;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_g;
    logic [23:0] m_out_l;
    logic [23:0] m_out_r;
    int          m_pk;
    int          m_cnt;
    int          tgt_gain;
    bit          tgt_mute;

    audio_gain_stage dut (
        .audio_clk     (audio_clk),
        .reset         (reset),
        .NewFrame      (NewFrame),
        .LeftRecData   (LeftRecData),
        .RightRecData  (RightRecData),
        .gain          (gain),
        .mute          (mute),
        .LeftPlayData  (LeftPlayData),
        .RightPlayData (RightPlayData),
        .clip          (clip),
        .busy          (busy),
        .PeakLevel     (PeakLevel)
    );

    always #5 audio_clk = ~audio_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // floor(s * g / 128), saturated to 24-bit signed
    function automatic void model_mul(input logic [23:0] s, input int g,
                                      output logic [23:0] y, output bit c);
        longint sv;
        longint p;
        longint q;
        sv = longint'($signed(s));
        p  = sv * g;
        q  = p / 128;
        if (p < 0 && (p % 128) != 0) q = q - 1;
        c = 1'b0;
        if (q > 8388607) begin
            q = 8388607;
            c = 1'b1;
        end else if (q < -8388608) begin
            q = -8388608;
            c = 1'b1;
        end
        y = q[23:0];
    endfunction

    function automatic int mag(input logic [23:0] v);
        longint x;
        x = longint'($signed(v));
        if (x < 0) x = -x;
        if (x > 8388607) x = 8388607;
        return int'(x);
    endfunction

    task automatic model_update(input logic [23:0] l, input logic [23:0] r);
        int top;
        m_out_l = l;
        m_out_r = r;
        if (tgt_mute) begin
            if (m_g > 0) m_g--;
        end else if (m_g < tgt_gain) begin
            m_g++;
        end else if (m_g > tgt_gain) begin
            m_g--;
        end
        top = ((mag(l) > mag(r) ? mag(l) : mag(r)) / 32768) % 256;
        if (top > m_pk) m_pk = top;
        else if (m_cnt == 255 && m_pk > 0) m_pk--;
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic chk_peak(input string tag);
`ifdef AUDIO_GAIN_STAGE_PEAK_METER_EN
        chk(tag, PeakLevel, m_pk);
`else
        chk(tag, PeakLevel, 0);
`endif
    endtask

    task automatic run_frame(input logic [23:0] l, input logic [23:0] r);
        logic [23:0] el;
        logic [23:0] er;
        bit          cl;
        bit          cr;
        model_mul(l, m_g, el, cl);
        model_mul(r, m_g, er, cr);
        @(posedge audio_clk); #1;
        chk("clip_fall", clip, 0);
        NewFrame = 1'b1;
        LeftRecData = l;
        RightRecData = r;
        @(posedge audio_clk); #1;
        NewFrame = 1'b0;
        LeftRecData = 24'($urandom);
        RightRecData = 24'($urandom);
        gain = 8'(tgt_gain);
        mute = tgt_mute;
        chk("busy_mul_l", busy, 1);
        @(posedge audio_clk); #1;
        chk("busy_mul_r", busy, 1);
        @(posedge audio_clk); #1;
        chk("busy_update", busy, 1);
        chk("hold_l", LeftPlayData, m_out_l);
        chk("clip_early", clip, 0);
        @(posedge audio_clk); #1;
        chk("busy_idle", busy, 0);
        chk("out_l", LeftPlayData, el);
        chk("out_r", RightPlayData, er);
        chk("clip", clip, 32'(cl | cr));
        model_update(el, er);
        chk_peak("peak");
    endtask

    task automatic model_reset();
        m_g = 0;
        m_out_l = 24'd0;
        m_out_r = 24'd0;
        m_pk = 0;
        m_cnt = 0;
    endtask

    initial begin
        logic [23:0] el;
        logic [23:0] er;
        bit          cl;
        bit          cr;
        reset = 1'b0;
        NewFrame = 1'b0;
        LeftRecData = 24'd0;
        RightRecData = 24'd0;
        gain = 8'h80;
        mute = 1'b0;
        tgt_gain = 8'h80;
        tgt_mute = 1'b0;
        model_reset();
        #23;
        chk("rst_l", LeftPlayData, 0);
        chk("rst_r", RightPlayData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clip", clip, 0);
        chk("rst_peak", PeakLevel, 0);
        reset = 1'b1;

        // Soft start to unity
        for (int i = 0; i < 200; i++) run_frame(24'h10_0000, 24'($urandom));
        chk("unity_l", LeftPlayData, 24'h10_0000);
        chk("unity_clip", clip, 0);

        // Ramp to 0xFF, then full-scale saturation on both channels
        tgt_gain = 8'hFF;
        for (int i = 0; i < 127; i++) run_frame(24'($urandom), 24'($urandom));
        run_frame(24'h7F_FFFF, 24'h80_0000);
        chk("sat_l", LeftPlayData, 24'h7F_FFFF);
        chk("sat_r", RightPlayData, 24'h80_0000);
        chk("sat_clip", clip, 1);

        // Ramp down to 0x40, then floor rounding of a negative sample
        tgt_gain = 8'h40;
        for (int i = 0; i < 191; i++) run_frame(24'($urandom), 24'($urandom));
        run_frame(24'hFF_FFFD, 24'h00_0003);
        chk("floor_l", LeftPlayData, 24'hFF_FFFE);
        chk("floor_r", RightPlayData, 24'h00_0001);

        // Random samples with gain/mute changed while frames are in flight
        for (int i = 0; i < 100; i++) begin
            tgt_gain = $urandom_range(0, 255);
            tgt_mute = ($urandom_range(0, 7) == 0);
            run_frame(24'($urandom), 24'($urandom));
        end

        // Second NewFrame during MUL_R is dropped
        tgt_gain = 8'h80;
        tgt_mute = 1'b0;
        model_mul(24'h12_3456, m_g, el, cl);
        model_mul(24'hF0_0000, m_g, er, cr);
        @(posedge audio_clk); #1;
        NewFrame = 1'b1;
        LeftRecData = 24'h12_3456;
        RightRecData = 24'hF0_0000;
        gain = 8'h80;
        mute = 1'b0;
        @(posedge audio_clk); #1;
        NewFrame = 1'b0;
        chk("dbl_busy1", busy, 1);
        @(posedge audio_clk); #1;
        chk("dbl_busy2", busy, 1);
        NewFrame = 1'b1;
        LeftRecData = 24'h55_5555;
        RightRecData = 24'h22_2222;
        @(posedge audio_clk); #1;
        NewFrame = 1'b0;
        chk("dbl_busy3", busy, 1);
        @(posedge audio_clk); #1;
        chk("dbl_busy4", busy, 0);
        chk("dbl_l", LeftPlayData, el);
        chk("dbl_r", RightPlayData, er);
        model_update(el, er);
        for (int i = 0; i < 4; i++) begin
            @(posedge audio_clk); #1;
            chk("dbl_idle", busy, 0);
            chk("dbl_hold", LeftPlayData, el);
        end

        // Ramp to unity, then mute ramps down to silence
        for (int i = 0; i < 80; i++) run_frame(24'($urandom), 24'($urandom));
        tgt_mute = 1'b1;
        for (int i = 0; i < 300; i++) run_frame(24'h10_0000, 24'($urandom));
        chk("mute_l", LeftPlayData, 0);
        chk("mute_r", RightPlayData, 0);

        // Reset during MUL_R aborts the frame
        tgt_mute = 1'b0;
        for (int i = 0; i < 10; i++) run_frame(24'h10_0000, 24'h10_0000);
        @(posedge audio_clk); #1;
        NewFrame = 1'b1;
        LeftRecData = 24'h20_0000;
        @(posedge audio_clk); #1;
        NewFrame = 1'b0;
        @(posedge audio_clk); #1;
        chk("abort_in_mul_r", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_l", LeftPlayData, 0);
        chk("abort_r", RightPlayData, 0);
        chk("abort_busy", busy, 0);
        chk("abort_clip", clip, 0);
        #6;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge audio_clk); #1;
            chk("abort_no_upd", LeftPlayData, 0);
            chk("abort_idle", busy, 0);
        end
        for (int i = 0; i < 5; i++) run_frame(24'($urandom), 24'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
